// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, fetch FSM states and well-known instruction words for the fetch unit.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] IMEM_DEFAULT_WORD = 32'h1234ABCD;
  localparam logic [INSTR_W-1:0] NOP_WORD          = 32'h0000_0000;

  typedef enum logic [0:0] {
    S_WAIT = 1'b0,  // address out, counting memory latency
    S_HELD = 1'b1   // data ready, capture blocked by stall
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_pc_reg.sv
// Word-address program counter: synchronous reset/load, enable-increment with natural wrap.
module instruction_fetch_unit_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst_i)       pc_q <= RESET_PC;
    else if (load_i) pc_q <= load_val_i;
    else if (inc_i)  pc_q <= pc_q + ADDR_W'(1);
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC on imem_addr for WAIT_CYCLES, then captures the word into IF/ID.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc, data_ready;

  instruction_fetch_unit_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst_i      (rst),
    .load_i     (branch_taken),
    .load_val_i (branch_target),
    .inc_i      (pc_inc),
    .pc_o       (pc)
  );

  assign data_ready = (state_q == S_HELD) || (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    pc_inc  = 1'b0;
    if (branch_taken) begin
      // in-flight fetch is dropped; IF/ID payload is left as-is behind valid=0
      state_d = S_WAIT;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (data_ready && !stall) begin
        instr_d = imem_data;
        ipc_d   = pc + ADDR_W'(1);
        valid_d = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_WAIT;
        cnt_d   = '0;
      end else if (data_ready) begin
        state_d = S_HELD;
      end else begin
        cnt_d = cnt_q + 4'd1;
        if (!stall) valid_d = 1'b0;
      end
      if (flush) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Three fetch units with different latency/reset PC, random control traffic, scoreboard vs. a latency model.
module tb_instruction_fetch_unit;

  localparam int N = 3;
  localparam int                WC [N] = '{1, 3, 2};
  localparam logic [15:0]       RP [N] = '{16'h0000, 16'h0000, 16'hFFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        stall [N];
  logic        flush [N];
  logic        br    [N];
  logic [15:0] tgt   [N];
  logic [15:0] addr  [N];
  logic [31:0] data  [N];
  logic [31:0] instr [N];
  logic [15:0] ipc   [N];
  logic        valid [N];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: mem_rd = 32'h8CE10010;
      16'h0001: mem_rd = 32'h20020005;
      16'h0002: mem_rd = 32'h00430820;
      16'h0003: mem_rd = 32'hAC010004;
      16'h0004: mem_rd = 32'h10000002;
      16'h0005: mem_rd = 32'h8C030008;
      16'hFFFF: mem_rd = 32'hDEADBEEF;
      default:  mem_rd = 32'h1234ABCD;
    endcase
  endfunction

  assign data[0] = mem_rd(addr[0]);
  assign data[1] = mem_rd(addr[1]);
  assign data[2] = mem_rd(addr[2]);

  instruction_fetch_unit #(.WAIT_CYCLES(WC[0]), .RESET_PC(RP[0])) u0 (
    .clk(clk), .rst(rst[0]), .stall(stall[0]), .flush(flush[0]), .branch_taken(br[0]),
    .branch_target(tgt[0]), .imem_addr(addr[0]), .imem_data(data[0]),
    .if_id_instr(instr[0]), .if_id_pc(ipc[0]), .if_id_valid(valid[0]));
  instruction_fetch_unit #(.WAIT_CYCLES(WC[1]), .RESET_PC(RP[1])) u1 (
    .clk(clk), .rst(rst[1]), .stall(stall[1]), .flush(flush[1]), .branch_taken(br[1]),
    .branch_target(tgt[1]), .imem_addr(addr[1]), .imem_data(data[1]),
    .if_id_instr(instr[1]), .if_id_pc(ipc[1]), .if_id_valid(valid[1]));
  instruction_fetch_unit #(.WAIT_CYCLES(WC[2]), .RESET_PC(RP[2])) u2 (
    .clk(clk), .rst(rst[2]), .stall(stall[2]), .flush(flush[2]), .branch_taken(br[2]),
    .branch_target(tgt[2]), .imem_addr(addr[2]), .imem_data(data[2]),
    .if_id_instr(instr[2]), .if_id_pc(ipc[2]), .if_id_valid(valid[2]));

  typedef struct packed {
    logic [N-1:0]        valid;
    logic [N-1:0]        chk_ifid;
    logic [N-1:0][15:0]  addr;
    logic [N-1:0][31:0]  instr;
    logic [N-1:0][15:0]  ipc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference: an address is usable once WAIT_CYCLES edges have elapsed since it was issued.
  logic [15:0] m_pc    [N];
  int          m_age   [N];
  logic [31:0] m_instr [N];
  logic [15:0] m_ipc   [N];
  logic        m_valid [N];

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d @%0t: got %h want %h", name, i, $time, act, exp);
    end
  endtask

  task automatic model_step_and_push();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        m_pc[i] = RP[i]; m_age[i] = 0; m_instr[i] = '0; m_ipc[i] = '0; m_valid[i] = 1'b0;
      end else if (br[i]) begin
        m_pc[i] = tgt[i]; m_age[i] = 0; m_valid[i] = 1'b0;
      end else if (m_age[i] + 1 >= WC[i] && !stall[i]) begin
        m_instr[i] = mem_rd(m_pc[i]);
        m_ipc[i]   = m_pc[i] + 16'd1;
        m_pc[i]    = m_pc[i] + 16'd1;
        m_age[i]   = 0;
        m_valid[i] = !flush[i];
      end else begin
        m_age[i] = (m_age[i] + 1 > WC[i]) ? WC[i] : m_age[i] + 1;
        if (!stall[i] || flush[i]) m_valid[i] = 1'b0;
      end
      e.valid[i]    = m_valid[i];
      e.chk_ifid[i] = m_valid[i] || rst[i];
      e.addr[i]     = m_pc[i];
      e.instr[i]    = m_instr[i];
      e.ipc[i]      = m_ipc[i];
    end
    q.push_back(e);
  endtask

  // Monitor: every edge the DUTs present a new IF/ID + address; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < N; i++) begin
          check("imem_addr", i, 32'(addr[i]), 32'(e.addr[i]));
          check("if_id_valid", i, 32'(valid[i]), 32'(e.valid[i]));
          if (e.chk_ifid[i]) begin
            check("if_id_instr", i, instr[i], e.instr[i]);
            check("if_id_pc", i, 32'(ipc[i]), 32'(e.ipc[i]));
          end
        end
      end
    end
  end

  // Directed opening: {rst, branch, flush, stall}, branch target 0x0001
  localparam int DN = 17;
  logic [3:0] dir [DN] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100,
                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0000, 4'b0010};

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; stall[i] = 1'b0; flush[i] = 1'b0; br[i] = 1'b0; tgt[i] = '0;
      m_pc[i] = '0; m_age[i] = 0; m_instr[i] = '0; m_ipc[i] = '0; m_valid[i] = 1'b0;
    end

    for (int k = 0; k < DN; k++) begin
      @(negedge clk);
      if (k == 3) begin
        check("first_capture_instr", 0, instr[0], 32'h8CE10010);
        check("first_capture_pc", 0, 32'(ipc[0]), 32'h0001);
      end
      if (k == 16) begin
        check("unmapped_word", 0, instr[0], 32'h1234ABCD);
        check("unmapped_valid", 0, 32'(valid[0]), 32'h1);
      end
      for (int i = 0; i < N; i++) begin
        {rst[i], br[i], flush[i], stall[i]} = dir[k];
        tgt[i] = 16'h0001;
      end
      model_step_and_push();
    end

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        rst[i]   = ($urandom_range(0, 59) == 0);
        br[i]    = ($urandom_range(0, 9) == 0);
        flush[i] = ($urandom_range(0, 7) == 0);
        stall[i] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
          0:       tgt[i] = 16'hFFFE + 16'($urandom_range(0, 1));
          default: tgt[i] = 16'($urandom_range(0, 7));
        endcase
      end
      model_step_and_push();
    end

    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; br[i] = 1'b0; flush[i] = 1'b0; stall[i] = 1'b0;
    end
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
